// File: rtl/serial_data_transmitter_if.sv
// Word-in / bit-out bundle for the serial framer.
// The source drives in_data/in_valid and observes the line status.
interface serial_data_transmitter_if #(
  parameter int DATA_WIDTH = 7
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_data;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, busy, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, busy, frame_done
  );
endinterface

// File: rtl/serial_data_transmitter.sv
// Parallel-to-serial framer: start(0), data LSB first, parity, stop(1); line idles high.
// A one-word holding register allows the next frame to follow with no idle gap.
module serial_data_transmitter #(
  parameter int DATA_WIDTH = 7,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                      clk,
  input logic                      reset,
  serial_data_transmitter_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  parity_q, parity_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_data_q, out_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  handshake;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      parity_q     <= 1'b0;
      cnt_q        <= '0;
      out_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      parity_q     <= parity_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A handshake in STOP only happens with the hold empty, so it loads the shifter directly.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    load_word   = bus.in_data;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        if (hold_full_q) begin
          state_d     = START;
          load        = 1'b1;
          load_word   = hold_q;
          hold_full_d = 1'b0;
        end else if (handshake) begin
          state_d = START;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shift_d  = load_word;
      parity_d = (^load_word) ^ PARITY_ODD;
    end
    if (handshake && state_q != IDLE && state_q != STOP) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end
  end

  // The line is registered, so its next value is decoded from the next state.
  always_comb begin
    out_data_d   = 1'b1;
    frame_done_d = 1'b0;
    case (state_d)
      START:   out_data_d = 1'b0;
      DATA:    out_data_d = shift_d[0];
      PARITY:  out_data_d = parity_q;
      STOP:    frame_done_d = 1'b1;
      default: out_data_d = 1'b1;
    endcase
  end

  assign handshake      = bus.in_valid & bus.in_ready;
  assign bus.in_ready   = (state_q == IDLE) | ~hold_full_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_data_transmitter.sv
// Scoreboard bench: each accepted word pushes its expected line bits, popped one per clock.
// A second instance with odd parity is exercised by the parity scenario.
module tb_serial_data_transmitter;

  localparam int DW = 7;
  localparam int FL = DW + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_data_transmitter_if #(.DATA_WIDTH(DW)) bus ();
  serial_data_transmitter_if #(.DATA_WIDTH(DW)) bus2 ();

  serial_data_transmitter #(.DATA_WIDTH(DW), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  serial_data_transmitter #(.DATA_WIDTH(DW), .PARITY_ODD(1'b1)) dutOdd (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct packed {logic line; logic done;} exp_t;
  exp_t scoreboard[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push_frame(input logic [DW-1:0] w);
    exp_t e;
    e.done = 1'b0;
    e.line = 1'b0;
    scoreboard.push_back(e);
    for (int i = 0; i < DW; i++) begin
      e.line = w[i];
      scoreboard.push_back(e);
    end
    e.line = ^w;
    scoreboard.push_back(e);
    e.line = 1'b1;
    e.done = 1'b1;
    scoreboard.push_back(e);
  endtask

  // Model: ready whenever fewer than a full frame of bits is still queued.
  task automatic tick(output bit accepted, output logic expLine, output logic expDone,
                      output logic expBusy, output logic expReady);
    exp_t e;
    accepted = bus.in_valid && (scoreboard.size() < FL) && !reset;
    if (accepted) push_frame(bus.in_data);
    @(posedge clk);
    #1;
    if (reset) scoreboard.delete();
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      expLine = e.line;
      expDone = e.done;
      expBusy = 1'b1;
    end else begin
      expLine = 1'b1;
      expDone = 1'b0;
      expBusy = 1'b0;
    end
    expReady = (scoreboard.size() < FL);
  endtask

  task automatic test_reset();
    bit acc;
    logic eL, eD, eB, eR;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(acc, eL, eD, eB, eR);
      vectors += 4;
      if (bus.out_data !== 1'b1) begin miscompares++; $display("[TB] FAIL reset.out_data c%0d: got %b want 1", c, bus.out_data); end
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset.in_ready c%0d: got %b want 1", c, bus.in_ready); end
      if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.busy c%0d: got %b want 0", c, bus.busy); end
      if (bus.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset.frame_done c%0d: got %b want 0", c, bus.frame_done); end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    bit acc;
    logic eL, eD, eB, eR;
    logic [9:0] seq = '0;
    int busyCnt = 0;
    int doneAt = -1;
    bus.in_data = 7'b0000111;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(acc, eL, eD, eB, eR);
      if (c == 0) bus.in_valid = 1'b0;
      vectors += 4;
      if (bus.out_data !== eL) begin miscompares++; $display("[TB] FAIL single.out_data c%0d: got %b want %b", c, bus.out_data, eL); end
      if (bus.frame_done !== eD) begin miscompares++; $display("[TB] FAIL single.frame_done c%0d: got %b want %b", c, bus.frame_done, eD); end
      if (bus.busy !== eB) begin miscompares++; $display("[TB] FAIL single.busy c%0d: got %b want %b", c, bus.busy, eB); end
      if (bus.in_ready !== eR) begin miscompares++; $display("[TB] FAIL single.in_ready c%0d: got %b want %b", c, bus.in_ready, eR); end
      if (c < 10) seq = {seq[8:0], bus.out_data};
      if (bus.busy === 1'b1) busyCnt++;
      if (bus.frame_done === 1'b1) doneAt = c;
    end
    vectors += 3;
    if (seq !== 10'b0111000011) begin miscompares++; $display("[TB] FAIL single.sequence: got %b want 0111000011", seq); end
    if (busyCnt != 10) begin miscompares++; $display("[TB] FAIL single.busy_cycles: got %0d want 10", busyCnt); end
    if (doneAt != 9) begin miscompares++; $display("[TB] FAIL single.done_cycle: got %0d want 9", doneAt); end
  endtask

  task automatic test_parity();
    bit acc;
    logic eL, eD, eB, eR;
    logic [9:0] seqEven = '0;
    logic [9:0] seqOdd = '0;
    bus.in_data = 7'b1000001;
    bus2.in_data = 7'b1000001;
    bus.in_valid = 1'b1;
    bus2.in_valid = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick(acc, eL, eD, eB, eR);
      if (c == 0) begin bus.in_valid = 1'b0; bus2.in_valid = 1'b0; end
      vectors += 2;
      if (bus.out_data !== eL) begin miscompares++; $display("[TB] FAIL parity.out_data c%0d: got %b want %b", c, bus.out_data, eL); end
      if (bus.frame_done !== eD) begin miscompares++; $display("[TB] FAIL parity.frame_done c%0d: got %b want %b", c, bus.frame_done, eD); end
      if (c < 10) begin
        seqEven = {seqEven[8:0], bus.out_data};
        seqOdd = {seqOdd[8:0], bus2.out_data};
      end
    end
    vectors += 3;
    if (seqEven !== 10'b0100000101) begin miscompares++; $display("[TB] FAIL parity.even_seq: got %b want 0100000101", seqEven); end
    if (seqOdd !== 10'b0100000111) begin miscompares++; $display("[TB] FAIL parity.odd_seq: got %b want 0100000111", seqOdd); end
    if (bus2.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL parity.odd_idle: got busy=%b want 0", bus2.busy); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    logic eL, eD, eB, eR;
    logic [DW-1:0] w[2] = '{7'h07, 7'h41};
    int idx = 0;
    int acceptAt[2] = '{-1, -1};
    int busyCnt = 0;
    int lastBusy = -1;
    int doneMask = 0;
    bus.in_data = w[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick(acc, eL, eD, eB, eR);
      if (acc) begin
        acceptAt[idx] = c;
        idx++;
        if (idx < 2) bus.in_data = w[idx];
        else bus.in_valid = 1'b0;
      end
      vectors += 4;
      if (bus.out_data !== eL) begin miscompares++; $display("[TB] FAIL b2b.out_data c%0d: got %b want %b", c, bus.out_data, eL); end
      if (bus.frame_done !== eD) begin miscompares++; $display("[TB] FAIL b2b.frame_done c%0d: got %b want %b", c, bus.frame_done, eD); end
      if (bus.busy !== eB) begin miscompares++; $display("[TB] FAIL b2b.busy c%0d: got %b want %b", c, bus.busy, eB); end
      if (bus.in_ready !== eR) begin miscompares++; $display("[TB] FAIL b2b.in_ready c%0d: got %b want %b", c, bus.in_ready, eR); end
      if (bus.busy === 1'b1) begin busyCnt++; lastBusy = c; end
      if (bus.frame_done === 1'b1) doneMask |= (1 << c);
    end
    vectors += 4;
    if (acceptAt[1] != 1) begin miscompares++; $display("[TB] FAIL b2b.second_accept: got cycle %0d want 1", acceptAt[1]); end
    if (busyCnt != 20 || lastBusy != 19) begin miscompares++; $display("[TB] FAIL b2b.contiguous: got %0d busy ending at %0d want 20 ending at 19", busyCnt, lastBusy); end
    if (doneMask != 32'h00080200) begin miscompares++; $display("[TB] FAIL b2b.done_cycles: got %h want 00080200", doneMask); end
    if (bus.out_data !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b.idle_line: got %b want 1", bus.out_data); end
  endtask

  task automatic test_hold_full();
    bit acc;
    logic eL, eD, eB, eR;
    logic [DW-1:0] w[3] = '{7'h15, 7'h6A, 7'h33};
    int idx = 0;
    int acceptAt[3] = '{-1, -1, -1};
    int lowReady = 0;
    bus.in_data = w[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 36; c++) begin
      tick(acc, eL, eD, eB, eR);
      if (acc) begin
        acceptAt[idx] = c;
        idx++;
        if (idx < 3) bus.in_data = w[idx];
        else bus.in_valid = 1'b0;
      end
      vectors += 4;
      if (bus.out_data !== eL) begin miscompares++; $display("[TB] FAIL hold.out_data c%0d: got %b want %b", c, bus.out_data, eL); end
      if (bus.frame_done !== eD) begin miscompares++; $display("[TB] FAIL hold.frame_done c%0d: got %b want %b", c, bus.frame_done, eD); end
      if (bus.busy !== eB) begin miscompares++; $display("[TB] FAIL hold.busy c%0d: got %b want %b", c, bus.busy, eB); end
      if (bus.in_ready !== eR) begin miscompares++; $display("[TB] FAIL hold.in_ready c%0d: got %b want %b", c, bus.in_ready, eR); end
      if (c >= 2 && c <= 9 && bus.in_ready === 1'b0) lowReady++;
    end
    vectors += 3;
    if (acceptAt[2] != 11) begin miscompares++; $display("[TB] FAIL hold.third_accept: got cycle %0d want 11", acceptAt[2]); end
    if (lowReady != 8) begin miscompares++; $display("[TB] FAIL hold.ready_low: got %0d low cycles want 8", lowReady); end
    if (scoreboard.size() != 0) begin miscompares++; $display("[TB] FAIL hold.drained: got %0d bits pending want 0", scoreboard.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    logic eL, eD, eB, eR;
    bus.in_data = 7'h2D;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c == 5) reset = 1'b1;
      if (c == 9) begin bus.in_data = 7'h4E; bus.in_valid = 1'b1; end
      tick(acc, eL, eD, eB, eR);
      reset = 1'b0;
      if (c == 0) bus.in_data = 7'h52;
      if (c >= 1 && acc) bus.in_valid = 1'b0;
      vectors += 4;
      if (bus.out_data !== eL) begin miscompares++; $display("[TB] FAIL rstmid.out_data c%0d: got %b want %b", c, bus.out_data, eL); end
      if (bus.frame_done !== eD) begin miscompares++; $display("[TB] FAIL rstmid.frame_done c%0d: got %b want %b", c, bus.frame_done, eD); end
      if (bus.busy !== eB) begin miscompares++; $display("[TB] FAIL rstmid.busy c%0d: got %b want %b", c, bus.busy, eB); end
      if (bus.in_ready !== eR) begin miscompares++; $display("[TB] FAIL rstmid.in_ready c%0d: got %b want %b", c, bus.in_ready, eR); end
      if (c == 4) begin
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid.hold_full: got in_ready=%b want 0", bus.in_ready); end
      end
      if (c == 5) begin
        vectors += 3;
        if (bus.out_data !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid.abort_line: got %b want 1", bus.out_data); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid.abort_busy: got %b want 0", bus.busy); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid.abort_ready: got %b want 1", bus.in_ready); end
      end
    end
    vectors++;
    if (scoreboard.size() != 0) begin miscompares++; $display("[TB] FAIL rstmid.drained: got %0d bits pending want 0", scoreboard.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus2.in_valid = 1'b0;
    bus2.in_data = '0;
    $display("[TB] starting serial_data_transmitter bench");
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_hold_full();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
